// File: rtl/glb_pkg.sv
// Shared constants and types for the GLB access arbiter.
package glb_pkg;

  localparam int GLB_ADDR_W = 32;
  localparam int GLB_DATA_W = 32;
  localparam int GLB_BE_W   = 4;

  // Active-low byte enables all high: the SRAM reads instead of writing.
  localparam logic [GLB_BE_W-1:0] GLB_WEB_RD = 4'hF;

  typedef enum logic {
    CLS_RD = 1'b0,
    CLS_WR = 1'b1
  } glb_class_e;

  // True when the read class wins this cycle. Contention alternates
  // against the class served last.
  function automatic logic glb_favour_rd(input logic rd_any, input logic wr_any,
                                         input glb_class_e last_class);
    return rd_any && (!wr_any || (last_class == CLS_WR));
  endfunction

endpackage

// File: rtl/glb_access_arbiter_if.sv
// Requester and SRAM bus bundle of the GLB access arbiter.
// The slave modport is the arbiter's view; master is the environment's
// view (FIFO controllers plus the SRAM macro).
interface glb_access_arbiter_if
  import glb_pkg::*;
#(
  parameter int NUM_RD = 64,
  parameter int NUM_WR = 32,
  parameter int ADDR_W = GLB_ADDR_W,
  parameter int DATA_W = GLB_DATA_W
);

  // Read requesters (ifmap lanes first, then ipsum lanes)
  logic [NUM_RD-1:0]             rd_req;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]             rd_gnt;
  logic [NUM_RD-1:0]             rd_rvalid;
  logic [DATA_W-1:0]             rd_rdata;

  // Write requesters (opsum lanes)
  logic [NUM_WR-1:0]               wr_req;
  logic [NUM_WR-1:0][ADDR_W-1:0]   wr_addr;
  logic [NUM_WR-1:0][GLB_BE_W-1:0] wr_web;
  logic [NUM_WR-1:0][DATA_W-1:0]   wr_wdata;
  logic [NUM_WR-1:0]               wr_gnt;

  // Single-port synchronous-read SRAM
  logic                glb_ce;
  logic [GLB_BE_W-1:0] glb_web;
  logic [ADDR_W-1:0]   glb_addr;
  logic [DATA_W-1:0]   glb_wdata;
  logic [DATA_W-1:0]   glb_rdata;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_web, wr_wdata, glb_rdata,
    input  rd_gnt, rd_rvalid, rd_rdata, wr_gnt,
    input  glb_ce, glb_web, glb_addr, glb_wdata
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_web, wr_wdata, glb_rdata,
    output rd_gnt, rd_rvalid, rd_rdata, wr_gnt,
    output glb_ce, glb_web, glb_addr, glb_wdata
  );

endinterface

// File: rtl/glb_access_arbiter_rr_arbiter.sv
// Round-robin lane picker. The search starts at the internal pointer and
// wraps; the pointer moves past the winner only when i_adv says the
// grant was actually issued.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  input  logic                 i_adv,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  int            w_cand;
  logic [IW-1:0] w_cand_idx;

  // First requesting lane at or after the pointer, modulo N.
  always_comb begin
    // NOTE: every output gets a default before the search so no path
    // leaves a value unassigned, which would infer a latch.
    o_gnt      = '0;
    o_gnt_idx  = '0;
    o_any      = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = int'(r_ptr) + i;
      if (w_cand >= N) w_cand = w_cand - N;
      w_cand_idx = IW'(w_cand);
      if (!o_any && i_req[w_cand_idx]) begin
        o_any             = 1'b1;
        o_gnt[w_cand_idx] = 1'b1;
        o_gnt_idx         = w_cand_idx;
      end
    end
  end

  // Pointer moves to the lane after the winner on an issued grant.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/glb_access_arbiter.sv
// Serialises per-lane GLB reads and writes onto one single-port SRAM.
// One access per cycle; reads return one cycle later tagged one-hot.
module glb_access_arbiter
  import glb_pkg::*;
#(
  parameter int NUM_RD = 64,
  parameter int NUM_WR = 32,
  parameter int ADDR_W = GLB_ADDR_W,
  parameter int DATA_W = GLB_DATA_W
) (
  input  logic clk,
  input  logic rst_n,
  glb_access_arbiter_if.slave bus
);

  localparam int RD_IW = $clog2(NUM_RD);
  localparam int WR_IW = $clog2(NUM_WR);

  logic [NUM_RD-1:0] w_rd_onehot;
  logic [RD_IW-1:0]  w_rd_idx;
  logic              w_rd_any;
  logic [NUM_WR-1:0] w_wr_onehot;
  logic [WR_IW-1:0]  w_wr_idx;
  logic              w_wr_any;

  logic              w_serve_rd;
  logic              w_serve_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  glb_class_e        r_last_class;
  logic              r_rd_pend;
  logic [RD_IW-1:0]  r_rd_pend_idx;

  rr_arbiter #(.N(NUM_RD)) u_rd_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (bus.rd_req),
    .i_adv     (w_serve_rd),
    .o_gnt     (w_rd_onehot),
    .o_gnt_idx (w_rd_idx),
    .o_any     (w_rd_any)
  );

  rr_arbiter #(.N(NUM_WR)) u_wr_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (bus.wr_req),
    .i_adv     (w_serve_wr),
    .o_gnt     (w_wr_onehot),
    .o_gnt_idx (w_wr_idx),
    .o_any     (w_wr_any)
  );

  // Pick the class to serve; nothing is granted while reset is held.
  always_comb begin
    w_serve_rd = 1'b0;
    w_serve_wr = 1'b0;
    if (rst_n) begin
      w_serve_rd = glb_favour_rd(w_rd_any, w_wr_any, r_last_class);
      w_serve_wr = w_wr_any && !w_serve_rd;
    end
  end

  // Drive grants and the SRAM command from the selected lane.
  always_comb begin
    bus.rd_gnt  = '0;
    bus.wr_gnt  = '0;
    bus.glb_ce  = 1'b0;
    bus.glb_web = GLB_WEB_RD;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_serve_rd) begin
      bus.rd_gnt = w_rd_onehot;
      bus.glb_ce = 1'b1;
      w_sel_addr = bus.rd_addr[w_rd_idx];
    end else if (w_serve_wr) begin
      bus.wr_gnt  = w_wr_onehot;
      bus.glb_ce  = 1'b1;
      bus.glb_web = bus.wr_web[w_wr_idx];
      w_sel_addr  = bus.wr_addr[w_wr_idx];
      w_sel_wdata = bus.wr_wdata[w_wr_idx];
    end
    bus.glb_addr  = w_sel_addr;
    bus.glb_wdata = w_sel_wdata;
  end

  // Return SRAM data to the lane whose read was issued last cycle.
  always_comb begin
    bus.rd_rvalid = '0;
    bus.rd_rdata  = '0;
    if (r_rd_pend) begin
      bus.rd_rvalid[r_rd_pend_idx] = 1'b1;
      bus.rd_rdata                 = bus.glb_rdata;
    end
  end

  // Track the class served last and the read awaiting its data.
  // A write with all byte enables off never marks a read pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_class  <= CLS_WR;
      r_rd_pend     <= 1'b0;
      r_rd_pend_idx <= '0;
    end else begin
      r_rd_pend <= w_serve_rd;
      if (w_serve_rd) begin
        r_rd_pend_idx <= w_rd_idx;
        r_last_class  <= CLS_RD;
      end else if (w_serve_wr) begin
        r_last_class  <= CLS_WR;
      end
    end
  end

endmodule

// File: tb/tb_glb_access_arbiter.sv
// Self-checking bench for glb_access_arbiter. Grants and SRAM command are
// checked in the grant cycle; expected read responses go to a scoreboard
// queue and are matched against rd_rvalid/rd_rdata when they fall due.
module tb_glb_access_arbiter;
  import glb_pkg::*;

  localparam int NUM_RD = 64;
  localparam int NUM_WR = 32;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  logic    clk;
  logic    rst_n;
  int      cyc;
  int      n_chk;
  int      n_err;
  rd_exp_t sb_q[$];

  glb_access_arbiter_if #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  glb_access_arbiter #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pattern-filled SRAM model; address 0x100 holds 0xDEADBEEF.
  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  always @(posedge clk) begin
    if (bus.glb_ce && bus.glb_web == GLB_WEB_RD) bus.glb_rdata <= sram_word(bus.glb_addr);
    else bus.glb_rdata <= 32'h0BAD_0000 ^ 32'(cyc);
  end

  function automatic logic [63:0] onehot(input int i);
    return 64'd1 << i;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Response monitor: rvalid must match the due scoreboard entry or be 0.
  always @(negedge clk) begin
    if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
      check("rvalid", bus.rd_rvalid, onehot(sb_q[0].idx));
      check("rdata", 64'(bus.rd_rdata), 64'(sb_q[0].data));
      void'(sb_q.pop_front());
    end else begin
      check("rvalid_idle", bus.rd_rvalid, 64'd0);
    end
  end

  task automatic clear_reqs();
    bus.rd_req   = '0;
    bus.rd_addr  = '0;
    bus.wr_req   = '0;
    bus.wr_addr  = '0;
    bus.wr_web   = '1;
    bus.wr_wdata = '0;
  endtask

  task automatic set_rd(input int lane, input logic [31:0] addr);
    bus.rd_req[lane[5:0]]  = 1'b1;
    bus.rd_addr[lane[5:0]] = addr;
  endtask

  task automatic set_wr(input int lane, input logic [31:0] addr, input logic [3:0] web,
                        input logic [31:0] wdata);
    bus.wr_req[lane[4:0]]   = 1'b1;
    bus.wr_addr[lane[4:0]]  = addr;
    bus.wr_web[lane[4:0]]   = web;
    bus.wr_wdata[lane[4:0]] = wdata;
  endtask

  // Check one cycle's grant/command, queue the expected read response if
  // tracked, then return just after the closing clock edge.
  task automatic step(input string tag, input logic [63:0] e_rd, input logic [31:0] e_wr,
                      input logic [3:0] e_web, input logic [31:0] e_addr,
                      input logic [31:0] e_wdata, input bit track);
    rd_exp_t e;
    @(negedge clk);
    check({tag, ".rd_gnt"}, bus.rd_gnt, e_rd);
    check({tag, ".wr_gnt"}, 64'(bus.wr_gnt), 64'(e_wr));
    check({tag, ".ce"}, 64'(bus.glb_ce), 64'((e_rd != 64'd0) || (e_wr != 32'd0)));
    check({tag, ".web"}, 64'(bus.glb_web), 64'(e_web));
    check({tag, ".addr"}, 64'(bus.glb_addr), 64'(e_addr));
    check({tag, ".wdata"}, 64'(bus.glb_wdata), 64'(e_wdata));
    if (track && e_rd != 64'd0) begin
      e.idx = 0;
      for (int i = 0; i < NUM_RD; i++) if (e_rd[i]) e.idx = i;
      e.data = sram_word(e_addr);
      e.due  = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 64'd0, 32'd0, 4'hF, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic apply_reset();
    clear_reqs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_reqs();
    bus.glb_rdata = '0;

    // Reset: requests present but every output held idle
    set_rd(1, 32'h10);
    set_wr(1, 32'h20, 4'h0, 32'h1);
    step("rst", 64'd0, 32'd0, 4'hF, 32'd0, 32'd0, 1'b1);
    check("rst.rdata", 64'(bus.rd_rdata), 64'd0);
    clear_reqs();
    rst_n = 1'b1;
    idle("post_rst");

    // Single read on lane 5
    set_rd(5, 32'h100);
    step("rd5", onehot(5), 32'd0, 4'hF, 32'h100, 32'd0, 1'b1);
    clear_reqs();
    idle("rd5.t1");
    idle("rd5.t2");

    // Read round-robin 3 -> 10 -> 40 -> 3 with requests held
    apply_reset();
    set_rd(3, 32'h300);
    set_rd(10, 32'hA00);
    set_rd(40, 32'h2800);
    step("rr0", onehot(3), 32'd0, 4'hF, 32'h300, 32'd0, 1'b1);
    step("rr1", onehot(10), 32'd0, 4'hF, 32'hA00, 32'd0, 1'b1);
    step("rr2", onehot(40), 32'd0, 4'hF, 32'h2800, 32'd0, 1'b1);
    step("rr3", onehot(3), 32'd0, 4'hF, 32'h300, 32'd0, 1'b1);
    clear_reqs();
    idle("rr.end");

    // Mixed classes from reset: rd0, wr2, rd0, wr2
    apply_reset();
    set_rd(0, 32'h80);
    set_wr(2, 32'h200, 4'h0, 32'h12345678);
    for (int k = 0; k < 2; k++) begin
      step("mix_rd", onehot(0), 32'd0, 4'hF, 32'h80, 32'd0, 1'b1);
      step("mix_wr", 64'd0, 32'd1 << 2, 4'h0, 32'h200, 32'h12345678, 1'b1);
    end
    clear_reqs();
    idle("mix.end");

    // Pointer wrap: bring pointer to 63, then 63 -> 0, pointer ends at 1
    apply_reset();
    set_rd(62, 32'h3E0);
    step("wrap62", onehot(62), 32'd0, 4'hF, 32'h3E0, 32'd0, 1'b1);
    clear_reqs();
    set_rd(63, 32'h3F0);
    set_rd(0, 32'h000);
    step("wrap63", onehot(63), 32'd0, 4'hF, 32'h3F0, 32'd0, 1'b1);
    step("wrap0", onehot(0), 32'd0, 4'hF, 32'h000, 32'd0, 1'b1);
    bus.rd_req[63] = 1'b0;
    set_rd(1, 32'h010);
    step("wrap_ptr1", onehot(1), 32'd0, 4'hF, 32'h010, 32'd0, 1'b1);
    clear_reqs();
    idle("wrap.end");

    // Reset during the response cycle of a read: no rvalid ever appears
    apply_reset();
    set_rd(7, 32'h700);
    step("mid_rd", onehot(7), 32'd0, 4'hF, 32'h700, 32'd0, 1'b0);
    clear_reqs();
    rst_n = 1'b0;
    step("mid_rst0", 64'd0, 32'd0, 4'hF, 32'd0, 32'd0, 1'b1);
    step("mid_rst1", 64'd0, 32'd0, 4'hF, 32'd0, 32'd0, 1'b1);
    rst_n = 1'b1;
    set_rd(9, 32'h900);
    set_wr(4, 32'h400, 4'h0, 32'h55AA55AA);
    step("mid_contest", onehot(9), 32'd0, 4'hF, 32'h900, 32'd0, 1'b1);
    bus.rd_req[9] = 1'b0;
    step("mid_wr4", 64'd0, 32'd1 << 4, 4'h0, 32'h400, 32'h55AA55AA, 1'b1);
    clear_reqs();
    idle("mid.end");

    // Partial write on lane 31, then an all-disabled write on lane 1
    set_wr(31, 32'h40, 4'b1100, 32'hCAFEF00D);
    step("pwr31", 64'd0, 32'd1 << 31, 4'b1100, 32'h40, 32'hCAFEF00D, 1'b1);
    clear_reqs();
    set_wr(1, 32'h44, 4'hF, 32'h0BADCAFE);
    step("nowr1", 64'd0, 32'd1 << 1, 4'hF, 32'h44, 32'h0BADCAFE, 1'b1);
    clear_reqs();
    idle("pwr.t1");
    idle("pwr.t2");

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
